mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 1024x32 byte-addressable data memory with sub-word
// loads/stores, alignment checking and the registered MEM/WB boundary.
module mem_wb_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemSize,
  input  logic        LoadSE,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic [4:0]  WR,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALUResult,
  output logic [4:0]  WB_WR,
  output logic        WB_RegWrite,
  output logic        WB_MemToReg,
  output logic        WB_Misalign,
  output logic [7:0]  MisalignCount
);

  localparam logic [1:0] SizeWord = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;

  logic [31:0] r_mem [0:1023];

  logic [31:0] r_readData;
  logic [31:0] r_aluResult;
  logic [4:0]  r_wr;
  logic        r_regWrite;
  logic        r_memToReg;
  logic        r_misalign;
  logic [7:0]  r_misalignCount;

  logic [9:0]  w_index;
  logic [1:0]  w_lane;
  logic        w_sizeValid;
  logic        w_misaligned;
  logic        w_fault;
  logic        w_doWrite;
  logic        w_doRead;
  logic [31:0] w_memWord;
  logic [3:0]  w_byteEn;
  logic [31:0] w_storeData;
  logic [7:0]  w_byteVal;
  logic [15:0] w_halfVal;
  logic [31:0] w_loadData;

  assign w_index   = Address[11:2];
  assign w_lane    = Address[1:0];
  assign w_memWord = r_mem[w_index];

  // Alignment: halves need A[0]=0, words need A[1:0]=0, bytes always legal.
  // The reserved size is neither legal nor misaligned, it is simply ignored.
  assign w_sizeValid  = (MemSize != 2'b11);
  assign w_misaligned = ((MemSize == SizeWord) && (w_lane != 2'b00)) ||
                        ((MemSize == SizeHalf) && w_lane[0]);
  assign w_fault      = (MemRead || MemWrite) && w_misaligned;
  assign w_doWrite    = MemWrite && w_sizeValid && !w_misaligned;
  assign w_doRead     = MemRead && w_sizeValid && !w_misaligned;

  always_comb begin
    w_byteEn    = 4'b0000;
    w_storeData = 32'h0;
    case (MemSize)
      SizeWord: begin
        w_byteEn    = 4'b1111;
        w_storeData = WriteData;
      end
      SizeHalf: begin
        w_byteEn    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_storeData = {2{WriteData[15:0]}};
      end
      SizeByte: begin
        w_byteEn    = 4'b0001 << w_lane;
        w_storeData = {4{WriteData[7:0]}};
      end
      default: begin
        w_byteEn    = 4'b0000;
        w_storeData = 32'h0;
      end
    endcase
  end

  // Reset only blocks writes; the array itself keeps its contents.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
    end else if (w_doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[i]) begin
          r_mem[w_index][8*i +: 8] <= w_storeData[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    w_byteVal = 8'h0;
    case (w_lane)
      2'd0:    w_byteVal = w_memWord[7:0];
      2'd1:    w_byteVal = w_memWord[15:8];
      2'd2:    w_byteVal = w_memWord[23:16];
      default: w_byteVal = w_memWord[31:24];
    endcase
  end

  assign w_halfVal = w_lane[1] ? w_memWord[31:16] : w_memWord[15:0];

  always_comb begin
    w_loadData = 32'h0;
    if (w_doRead) begin
      case (MemSize)
        SizeWord: w_loadData = w_memWord;
        SizeHalf: w_loadData = LoadSE ? {{16{w_halfVal[15]}}, w_halfVal}
                                      : {16'h0, w_halfVal};
        SizeByte: w_loadData = LoadSE ? {{24{w_byteVal[7]}}, w_byteVal}
                                      : {24'h0, w_byteVal};
        default:  w_loadData = 32'h0;
      endcase
    end
  end

  // Read happens before the write on the same edge, so a combined
  // read+write returns the old contents.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_readData      <= 32'h0;
      r_aluResult     <= 32'h0;
      r_wr            <= 5'h0;
      r_regWrite      <= 1'b0;
      r_memToReg      <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalignCount <= 8'h0;
    end else begin
      r_readData  <= w_loadData;
      r_aluResult <= Address;
      r_wr        <= WR;
      r_regWrite  <= RegWrite && !w_fault;
      r_memToReg  <= MemToReg;
      r_misalign  <= w_fault;
      if (w_fault && (r_misalignCount != 8'hFF)) begin
        r_misalignCount <= r_misalignCount + 8'd1;
      end
    end
  end

  assign WB_ReadData   = r_readData;
  assign WB_ALUResult  = r_aluResult;
  assign WB_WR         = r_wr;
  assign WB_RegWrite   = r_regWrite;
  assign WB_MemToReg   = r_memToReg;
  assign WB_Misalign   = r_misalign;
  assign MisalignCount = r_misalignCount;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage plus hand-written sequences
// for counter saturation and asynchronous reset behaviour.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemWrite, MemRead, LoadSE, RegWrite, MemToReg;
  logic [1:0]  MemSize;
  logic [31:0] Address, WriteData;
  logic [4:0]  WR;
  logic [31:0] WB_ReadData, WB_ALUResult;
  logic [4:0]  WB_WR;
  logic        WB_RegWrite, WB_MemToReg, WB_Misalign;
  logic [7:0]  MisalignCount;

  int testsRun = 0;
  int failCount = 0;

  mem_wb_stage dut (
    .Clk(Clk), .Rst(Rst), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemSize(MemSize), .LoadSE(LoadSE), .Address(Address),
    .WriteData(WriteData), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .WR(WR), .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult),
    .WB_WR(WB_WR), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
    .WB_Misalign(WB_Misalign), .MisalignCount(MisalignCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wrEn;
    logic        rdEn;
    logic [1:0]  size;
    logic        se;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        regW;
    logic        m2r;
    logic [4:0]  wr;
    logic [31:0] expRd;
    logic        expRegW;
    logic        expMis;
    logic [7:0]  expCnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wrEn, logic rdEn, logic [1:0] size, logic se,
                              logic [31:0] addr, logic [31:0] wdata, logic regW,
                              logic m2r, logic [4:0] wr, logic [31:0] expRd,
                              logic expRegW, logic expMis, logic [7:0] expCnt);
    vec_t v;
    v.wrEn = wrEn; v.rdEn = rdEn; v.size = size; v.se = se; v.addr = addr;
    v.wdata = wdata; v.regW = regW; v.m2r = m2r; v.wr = wr; v.expRd = expRd;
    v.expRegW = expRegW; v.expMis = expMis; v.expCnt = expCnt;
    return v;
  endfunction

  // Drives one instruction onto the stage inputs.
  task automatic applyStimulus(input vec_t v);
    MemWrite = v.wrEn; MemRead = v.rdEn; MemSize = v.size; LoadSE = v.se;
    Address = v.addr; WriteData = v.wdata; RegWrite = v.regW;
    MemToReg = v.m2r; WR = v.wr;
  endtask

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ReadData"}, WB_ReadData, 32'h0);
    checkOutput({tag, " ALUResult"}, WB_ALUResult, 32'h0);
    checkOutput({tag, " WR"}, {27'h0, WB_WR}, 32'h0);
    checkOutput({tag, " RegWrite"}, {31'h0, WB_RegWrite}, 32'h0);
    checkOutput({tag, " MemToReg"}, {31'h0, WB_MemToReg}, 32'h0);
    checkOutput({tag, " Misalign"}, {31'h0, WB_Misalign}, 32'h0);
    checkOutput({tag, " Count"}, {24'h0, MisalignCount}, 32'h0);
  endtask

  // Applies a vector, lets one rising edge capture it, samples on the falling edge.
  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput({tag, " ReadData"}, WB_ReadData, v.expRd);
    checkOutput({tag, " ALUResult"}, WB_ALUResult, v.addr);
    checkOutput({tag, " WR"}, {27'h0, WB_WR}, {27'h0, v.wr});
    checkOutput({tag, " RegWrite"}, {31'h0, WB_RegWrite}, {31'h0, v.expRegW});
    checkOutput({tag, " MemToReg"}, {31'h0, WB_MemToReg}, {31'h0, v.m2r});
    checkOutput({tag, " Misalign"}, {31'h0, WB_Misalign}, {31'h0, v.expMis});
    checkOutput({tag, " Count"}, {24'h0, MisalignCount}, {24'h0, v.expCnt});
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    //            wr rd size  se addr          wdata         rw m2r wr     expRd         eRW mis cnt
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h0000_0000, 32'h1122_3344, 0, 0, 5'd0,  32'h0,         0, 0, 8'd0));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 5'd0,  32'h0,         0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0010, 32'h0,         1, 1, 5'd3,  32'hDEAD_BEEF, 1, 0, 8'd0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_0013, 32'h0000_0080, 0, 0, 5'd0,  32'h0,         0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 2'b10, 1, 32'h0000_0013, 32'h0,         1, 1, 5'd4,  32'hFFFF_FF80, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_0013, 32'h0,         1, 1, 5'd5,  32'h0000_0080, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0010, 32'h0,         1, 1, 5'd6,  32'h80AD_BEEF, 1, 0, 8'd0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h0000_0012, 32'hABCD_1234, 0, 0, 5'd0,  32'h0,         0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 2'b01, 1, 32'h0000_0012, 32'h0,         1, 1, 5'd7,  32'h0000_1234, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 2'b01, 1, 32'h0000_0011, 32'h0,         1, 1, 5'd8,  32'h0,         0, 1, 8'd1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0010, 32'h0,         1, 1, 5'd9,  32'h1234_BEEF, 1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 2'b01, 1, 32'h0000_0010, 32'h0,         1, 1, 5'd10, 32'hFFFF_BEEF, 1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_0011, 32'h0,         1, 1, 5'd11, 32'h0000_00BE, 1, 0, 8'd1));
    vecs.push_back(mk(1, 1, 2'b11, 0, 32'h0000_0010, 32'hFFFF_FFFF, 1, 1, 5'd12, 32'h0,         1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0010, 32'h0,         1, 1, 5'd13, 32'h1234_BEEF, 1, 0, 8'd1));
    vecs.push_back(mk(1, 1, 2'b00, 0, 32'h0000_0010, 32'hCAFE_F00D, 1, 1, 5'd14, 32'h1234_BEEF, 1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0010, 32'h0,         1, 1, 5'd15, 32'hCAFE_F00D, 1, 0, 8'd1));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_1011, 32'h0000_0055, 0, 0, 5'd0,  32'h0,         0, 0, 8'd1));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0010, 32'h0,         1, 1, 5'd16, 32'hCAFE_550D, 1, 0, 8'd1));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h0000_1234, 32'h0,         1, 0, 5'd17, 32'h0,         1, 0, 8'd1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h0000_0002, 32'hFFFF_FFFF, 1, 0, 5'd18, 32'h0,         0, 1, 8'd2));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0000, 32'h0,         1, 1, 5'd19, 32'h1122_3344, 1, 0, 8'd2));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0001, 32'h0,         1, 1, 5'd20, 32'h0,         0, 1, 8'd3));
    vecs.push_back(mk(0, 1, 2'b10, 1, 32'h0000_0003, 32'h0,         1, 1, 5'd21, 32'h0000_0011, 1, 0, 8'd3));

    idle = mk(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 0, 8'd0);
    applyStimulus(idle);
    Rst = 1'b0;
    #1;
    checkAllZero("reset");
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], $sformatf("v%0d", i));
    end

    // Saturation: 260 misaligned word stores on top of the 3 faults above.
    v = mk(1, 0, 2'b00, 0, 32'h0000_0002, 32'hFFFF_FFFF, 1, 0, 5'd1, 32'h0, 0, 1, 8'd255);
    applyStimulus(v);
    for (int n = 0; n < 259; n++) begin
      @(posedge Clk);
    end
    runVector(v, "sat260");
    runVector(mk(0, 1, 2'b00, 0, 32'h0, 32'h0, 1, 1, 5'd2, 32'h1122_3344, 1, 0, 8'd255), "satLoad");

    // Asynchronous reset while a store to word 0 is waiting for its edge.
    applyStimulus(mk(1, 0, 2'b00, 0, 32'h0, 32'hBAD0_BAD0, 1, 1, 5'd9, 32'h0, 0, 0, 8'd0));
    #2;
    Rst = 1'b0;
    #1;
    checkAllZero("asyncRst");
    @(posedge Clk);
    @(negedge Clk);
    checkAllZero("heldRst");
    applyStimulus(mk(0, 1, 2'b00, 0, 32'h0, 32'h0, 1, 1, 5'd4, 32'h0, 0, 0, 8'd0));
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("postRst ReadData", WB_ReadData, 32'h1122_3344);
    checkOutput("postRst WR", {27'h0, WB_WR}, 32'd4);
    checkOutput("postRst RegWrite", {31'h0, WB_RegWrite}, 32'h1);
    checkOutput("postRst Count", {24'h0, MisalignCount}, 32'h0);
    runVector(mk(0, 1, 2'b00, 0, 32'h0000_0010, 32'h0, 1, 0, 5'd5, 32'hCAFE_550D, 1, 0, 8'd0), "postRstW4");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
